// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: VGA receive-side timing checker, pixel coordinate/colour recovery and per-frame signature (VGA_RX_CRC_EN selects a CRC-16 signature, otherwise frame_sig is 0)
module vga_rx_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACT       = 640,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACT       = 480,
    parameter int V_FP        = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        locked,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_sig
);
    localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [9:0] HA0    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HA1    = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] VA0    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VA1    = 10'(V_SYNC + V_BP + V_ACT);
    localparam int         GW     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [11:0]   rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic [9:0]    hc_q, hc_d, vc_q, vc_d;
    logic          seen_q, seen_d, lerr_q, lerr_d;
    logic [GW-1:0] good_q, good_d;
    logic [7:0]    err_q, err_d;
    logic          pix_valid_q, pix_valid_d, frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
    logic [9:0]    pix_x_q, pix_x_d;
    logic [8:0]    pix_y_q, pix_y_d;
    logic [11:0]   pix_rgb_q, pix_rgb_d;
    logic          hs_fall, vs_fall, line_err, good, act, drop;

    assign hs_fall  = hs2_q & ~hs1_q;
    assign vs_fall  = vs2_q & ~vs1_q;
    assign line_err = hs_fall && seen_q && hc_q != H_LAST;
    assign good     = vc_q == V_LAST && !lerr_q && !line_err;
    assign act      = hc_q >= HA0 && hc_q < HA1 && vc_q >= VA0 && vc_q < VA1;

    // input sampling, counters and per-frame line-error tracking
    always_comb begin
        hs1_d  = hs;
        vs1_d  = vs;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        rgb1_d = {r, g, b};
        rgb2_d = rgb1_q;
        hc_d   = hs_fall ? 10'd0 : (hc_q == 10'h3FF ? hc_q : hc_q + 10'd1);
        vc_d   = vs_fall ? 10'd0 : ((hs_fall && vc_q != 10'h3FF) ? vc_q + 10'd1 : vc_q);
        seen_d = drop ? 1'b0 : (seen_q | hs_fall);
        lerr_d = vs_fall ? 1'b0 : (lerr_q | line_err);
    end

    // lock FSM next state, good-frame counter and saturating error count
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        drop    = 1'b0;
        case (state_q)
            UNLOCKED: if (vs_fall) begin
                state_d = ACQUIRE;
                good_d  = '0;
            end
            ACQUIRE: if (vs_fall) begin
                good_d  = good ? good_q + 1'b1 : '0;
                state_d = (good && good_q + 1'b1 == GW'(LOCK_FRAMES)) ? LOCKED : ACQUIRE;
            end
            LOCKED: if (line_err || (vs_fall && !good)) begin
                state_d = UNLOCKED;
                drop    = 1'b1;
                err_d   = err_q == 8'hFF ? err_q : err_q + 8'd1;
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // registered pixel and frame-status outputs
    always_comb begin
        pix_valid_d  = act && state_q == LOCKED;
        pix_x_d      = hc_q - HA0;
        pix_y_d      = 9'(vc_q - VA0);
        pix_rgb_d    = rgb2_q;
        frame_done_d = vs_fall;
        frame_ok_d   = vs_fall ? (good && state_q != UNLOCKED) : frame_ok_q;
    end

    // lock FSM state register
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) state_q <= UNLOCKED;
        else       state_q <= state_d;
    end

    // datapath registers; syncs reset to the idle-high level
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            hs1_q <= 1'b1; vs1_q <= 1'b1; hs2_q <= 1'b1; vs2_q <= 1'b1;
            rgb1_q <= '0; rgb2_q <= '0; hc_q <= '0; vc_q <= '0;
            seen_q <= 1'b0; lerr_q <= 1'b0; good_q <= '0; err_q <= '0;
            pix_valid_q <= 1'b0; pix_x_q <= '0; pix_y_q <= '0; pix_rgb_q <= '0;
            frame_done_q <= 1'b0; frame_ok_q <= 1'b0;
        end else begin
            hs1_q <= hs1_d; vs1_q <= vs1_d; hs2_q <= hs2_d; vs2_q <= vs2_d;
            rgb1_q <= rgb1_d; rgb2_q <= rgb2_d; hc_q <= hc_d; vc_q <= vc_d;
            seen_q <= seen_d; lerr_q <= lerr_d; good_q <= good_d; err_q <= err_d;
            pix_valid_q <= pix_valid_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_rgb_q <= pix_rgb_d;
            frame_done_q <= frame_done_d; frame_ok_q <= frame_ok_d;
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_q, crc_d, sig_q, sig_d;

    function automatic logic [15:0] crc12(input logic [15:0] c_in, input logic [11:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 11; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    // CRC over active pixels while acquiring or locked; restarts at every frame boundary
    always_comb begin
        crc_d = vs_fall ? 16'hFFFF : ((act && state_q != UNLOCKED) ? crc12(crc_q, rgb2_q) : crc_q);
        sig_d = vs_fall ? crc_q : sig_q;
    end

    // CRC accumulator and latched frame signature
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            crc_q <= 16'hFFFF;
            sig_q <= '0;
        end else begin
            crc_q <= crc_d;
            sig_q <= sig_d;
        end
    end

    assign frame_sig = sig_q;
`else
    assign frame_sig = '0;
`endif

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign locked     = state_q == LOCKED;
    assign err_cnt    = err_q;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed bench for vga_rx_monitor on a scaled-down 17x10 raster
module tb_vga_rx_monitor;
    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    logic        vga_clk = 1'b0, clrn = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [11:0] rgb = '0;
    logic        pix_valid, frame_done, frame_ok, locked;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_rgb;
    logic [7:0]  err_cnt;
    logic [15:0] frame_sig;

    int passed = 0, total = 0, cyc = 0;
    int nvalid = 0, first_cyc = 0, bad_rgb = 0, fall_cyc = 0, ndone = 0;
    int mark_cyc = 0, act0_cyc = 0, vs_cyc = 0;
    int snap_nvalid = 0, snap_lat = 0, done_lat = 0;
    logic        locked_prev = 1'b0, zero_col = 1'b0;
    logic [9:0]  first_x = '0, last_x = '0, snap_fx = '0, snap_lx = '0;
    logic [8:0]  first_y = '0, last_y = '0, snap_fy = '0, snap_ly = '0;
    logic [11:0] first_rgb = '0, last_rgb = '0, snap_frgb = '0, snap_lrgb = '0;
    logic        snap_ok = 1'b0, snap_locked = 1'b0;
    logic [7:0]  snap_err = '0;
    logic [15:0] snap_sig = '0, exp_sig = '0;

    vga_rx_monitor #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF), .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk), .clrn(clrn), .hs(hs), .vs(vs),
        .r(rgb[11:8]), .g(rgb[7:4]), .b(rgb[3:0]),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
        .err_cnt(err_cnt), .frame_sig(frame_sig)
    );

    always #20 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] crc_zero(input int npix);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < npix * 12; i++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    // per-frame statistics gathered away from the active edge, snapshotted on frame_done
    always @(negedge vga_clk) begin
        if (pix_valid) begin
            if (nvalid == 0) begin
                first_cyc = cyc; first_x = pix_x; first_y = pix_y; first_rgb = pix_rgb;
            end
            last_x = pix_x; last_y = pix_y; last_rgb = pix_rgb;
            nvalid++;
            if (pix_rgb !== (zero_col ? 12'h000 : {pix_x[3:0], pix_y[3:0], 4'h5})) bad_rgb++;
        end
        if (locked_prev && !locked) fall_cyc = cyc;
        locked_prev = locked;
        if (frame_done) begin
            ndone++;
            done_lat = cyc - vs_cyc;
            snap_ok = frame_ok; snap_locked = locked; snap_err = err_cnt; snap_sig = frame_sig;
            snap_nvalid = nvalid; snap_lat = first_cyc - act0_cyc;
            snap_fx = first_x; snap_fy = first_y; snap_frgb = first_rgb;
            snap_lx = last_x; snap_ly = last_y; snap_lrgb = last_rgb;
            nvalid = 0;
        end
    end

    task automatic frame(input int nlines, input int short_ln, input int rst_ln, input logic zero);
        int len, ax, ay;
        zero_col = zero;
        for (int y = 0; y < nlines; y++) begin
            len = (y == short_ln) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                @(negedge vga_clk);
                clrn = 1'b1;
                ax = x - HS - HB;
                ay = y - VS - VB;
                hs = x >= HS;
                vs = y >= VS;
                rgb = (ax >= 0 && ax < HA && ay >= 0 && ay < VA && !zero) ? {ax[3:0], ay[3:0], 4'h5} : 12'h000;
                if (ax == 0 && ay == 0) act0_cyc = cyc;
                if (x == 0 && y == 0) vs_cyc = cyc;
                if (x == 0 && y == short_ln + 1) mark_cyc = cyc;
                if (y == rst_ln && x == 10) begin
                    clrn = 1'b0;
                    #1;
                    check("rst_mid_valid", pix_valid, 0);
                    check("rst_mid_locked", locked, 0);
                    check("rst_mid_err", err_cnt, 0);
                    check("rst_mid_ok", frame_ok, 0);
                end
            end
        end
    endtask

    initial begin
`ifdef VGA_RX_CRC_EN
        exp_sig = crc_zero(HA * VA);
`else
        exp_sig = 16'h0000;
`endif
        repeat (3) @(negedge vga_clk);
        #1;
        check("rst_valid", pix_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err_cnt, 0);
        check("rst_sig", frame_sig, 0);
        @(negedge vga_clk);
        clrn = 1'b1;
        frame(VT, -1, -1, 1'b0);
        frame(VT, -1, -1, 1'b0);
        check("f1_ok", snap_ok, 1);
        check("f1_not_locked", snap_locked, 0);
        check("done_latency", done_lat, 2);
        frame(VT, -1, -1, 1'b0);
        check("lock_at_3rd_fall", snap_locked, 1);
        check("f2_ok", snap_ok, 1);
        frame(VT, -1, -1, 1'b0);
        check("f3_nvalid", snap_nvalid, HA * VA);
        check("first_x", snap_fx, 0);
        check("first_y", snap_fy, 0);
        check("first_rgb", snap_frgb, 12'h005);
        check("first_latency", snap_lat, 3);
        check("last_x", snap_lx, HA - 1);
        check("last_y", snap_ly, VA - 1);
        check("last_rgb", snap_lrgb, 12'h735);
        check("f3_ok", snap_ok, 1);
        check("f3_err", snap_err, 0);
        frame(VT, -1, -1, 1'b0);
        check("f4_nvalid", snap_nvalid, HA * VA);
        check("f4_ok", snap_ok, 1);
        frame(VT, 5, -1, 1'b0);
        check("short_drop_time", fall_cyc - mark_cyc, 2);
        check("short_unlocked", locked, 0);
        check("short_err", err_cnt, 1);
        frame(VT, -1, -1, 1'b0);
        check("short_frame_ok", snap_ok, 0);
        check("short_snap_err", snap_err, 1);
        frame(VT, -1, -1, 1'b0);
        check("reacq_ok", snap_ok, 1);
        check("reacq_not_locked", snap_locked, 0);
        frame(VT, -1, -1, 1'b0);
        check("relocked", snap_locked, 1);
        check("relock_err", snap_err, 1);
        frame(VT, -1, 5, 1'b0);
        frame(VT, -1, -1, 1'b0);
        check("post_rst_1st_fall", snap_locked, 0);
        frame(VT + 1, -1, -1, 1'b0);
        check("post_rst_2nd_fall", snap_locked, 0);
        check("post_rst_f_ok", snap_ok, 1);
        frame(VT, -1, -1, 1'b1);
        check("long_frame_ok", snap_ok, 0);
        check("long_not_locked", snap_locked, 0);
        check("long_err", snap_err, 0);
        frame(VT, -1, -1, 1'b1);
        check("cnt_cleared", snap_locked, 0);
        check("after_long_ok", snap_ok, 1);
        frame(VT, -1, -1, 1'b1);
        check("relock_after_long", snap_locked, 1);
        check("sig_zero_a", snap_sig, exp_sig);
        frame(VT, -1, -1, 1'b0);
        check("sig_zero_b", snap_sig, exp_sig);
        check("zero_nvalid", snap_nvalid, HA * VA);
        check("rgb_map", bad_rgb, 0);
        check("done_pulses", ndone, 16);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
